integer_muldiv_execute: RTL
===========================

# integer_muldiv_execute

Parametrised iterative multiply/divide execution unit for the RV32M instructions (mul, mulh, mulhsu, mulhu, div, divu, rem, remu). It sits beside the single-cycle integer ALU as a second integer functional unit. It accepts one operation at a time from the integer issue queue through a valid/ready handshake and computes it bit-serially in WIDTH iterations. The result, tagged with its ROB id, is presented on a back-pressurable writeback port, and the unit is squashed by a pipeline flush.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be even and ≥ 4.
- ROB_ID_WIDTH, 5, width of the ROB tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_aL  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  operation offered.
- issue_ready  out  1  unit can accept; equals (state == IDLE).
- src1  in  WIDTH  rs1 value (dividend / multiplicand).
- src2  in  WIDTH  rs2 value (divisor / multiplier).
- funct3  in  3  RV32M opcode select.
- rob_id  in  ROB_ID_WIDTH  tag of the offered instruction.
- flush  in  1  squash any in-flight operation.
- wb_valid  out  1  result available; equals (state == DONE).
- wb_ready  in  1  consumer accepts the result.
- wb_rob_id  out  ROB_ID_WIDTH  tag of the result.
- wb_data  out  WIDTH  result.

## Operation
- funct3 encoding:
  - 000 mul: low WIDTH bits of the product.
  - 001 mulh: high WIDTH bits, signed×signed.
  - 010 mulhsu: high WIDTH bits, signed src1 × unsigned src2.
  - 011 mulhu: high WIDTH bits, unsigned×unsigned.
  - 100 div, 101 divu: quotient, signed / unsigned.
  - 110 rem, 111 remu: remainder, signed / unsigned.
- States: IDLE, BUSY, DONE.
- IDLE → BUSY on issue_valid && issue_ready && !flush.
  - Latch funct3, rob_id, the operand absolute values (signed operands only), and the result sign.
  - Load the iteration counter with WIDTH; the counter is $clog2(WIDTH+1) bits wide.
- Multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
  - Final sign fix is two's-complement negation of the full 2·WIDTH product when the sign flag is set.
  - Then select the low or high half.
- Divide: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
  - Quotient sign = src1 sign XOR src2 sign.
  - Remainder sign = dividend sign.
- Special cases bypass the iterations; IDLE → DONE directly on accept:
  - Divide by zero: quotient = all ones; remainder = src1.
  - Signed overflow (src1 = 1 followed by WIDTH−1 zeros, src2 = all ones): quotient = src1; remainder = 0.
- BUSY: one iteration per cycle, counter decrements; when the counter reaches 0, go to DONE with the final sign-fixed result registered into wb_data.
- DONE: hold wb_data and wb_rob_id stable until wb_valid && wb_ready, then go to IDLE. issue_ready stays low throughout DONE.
- flush (synchronous): any state → IDLE at the next edge; the in-flight operation is discarded.
  - flush and an issue handshake in the same cycle: the flush wins and the operation is dropped.
  - flush and wb_ready in the same cycle in DONE: the transfer is treated as squashed; the consumer is flushed too.
- rst_aL low (asynchronous, including mid-operation):
  - state = IDLE, issue_ready = 1, wb_valid = 0, wb_data = 0, wb_rob_id = 0, counter = 0.

## Timing
- Normal ops: accept at edge E0; iterations on edges E1…E(WIDTH); wb_valid is high after edge E(WIDTH). This is WIDTH cycles of latency (32 at default).
- Special-case divides: wb_valid is high after edge E1 (latency 1).
- With wb_ready held high, the writeback handshake completes in the first DONE cycle. The earliest next accept is the cycle after that, so throughput is one op per WIDTH+2 cycles.
- issue_ready and wb_valid are decoded directly from registered state (no combinational path from inputs).
- wb_data and wb_rob_id change only on the BUSY→DONE or IDLE→DONE edge.

## Test plan
- mul 7 × 0xFFFFFFFD:
  - Required: wb_data = 0xFFFFFFEB, wb_valid rises exactly 32 cycles after the accept edge, wb_rob_id echoes the issued tag.
- mulh/mulhsu/mulhu:
  - mulh 0x80000000 × 0x80000000 → 0x40000000.
  - mulhsu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide 0xFFFFFFF9 / 2:
  - div → 0xFFFFFFFD; rem → 0xFFFFFFFF.
  - divu 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Special cases, each with wb_valid 1 cycle after accept:
  - divu 5 / 0 → 0xFFFFFFFF.
  - remu 5 / 0 → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - rem of the same operands → 0.
- Back-pressure:
  - Hold wb_ready low for 5 cycles in DONE → wb_valid, wb_data and wb_rob_id stay stable and issue_ready stays 0.
  - Raising wb_ready completes the transfer; issue_ready = 1 on the next cycle.
- Flush and reset:
  - flush at iteration 10 → IDLE next edge and no wb_valid.
  - flush coincident with an issue handshake → no op started.
  - rst_aL pulsed low mid-BUSY → all outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/integer_muldiv_execute.sv
// integer_muldiv_execute
//   Iterative RV32M multiply/divide unit. Accepts one operation at a time,
//   computes it bit-serially in WIDTH iterations, and holds the tagged result
//   on a back-pressurable writeback port until it is consumed.
//
// Ports
//   clk          clock, rising edge
//   rst_aL       asynchronous active-low reset
//   issue_valid  operation offered          issue_ready  unit idle, can accept
//   src1, src2   operands                   funct3       RV32M op select
//   rob_id       tag of offered op          flush        squash in-flight op
//   wb_valid     result available           wb_ready     consumer accepts
//   wb_rob_id    tag of result              wb_data      result
//
// State | meaning
// IDLE  | waiting for an operation; issue_ready high
// BUSY  | one multiply/divide iteration per cycle, counter counts down
// DONE  | result held on writeback port until wb_ready
module integer_muldiv_execute #(
    parameter int WIDTH        = 32,
    parameter int ROB_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_aL,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [WIDTH-1:0]        src1,
    input  logic [WIDTH-1:0]        src2,
    input  logic [2:0]              funct3,
    input  logic [ROB_ID_WIDTH-1:0] rob_id,
    input  logic                    flush,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [ROB_ID_WIDTH-1:0] wb_rob_id,
    output logic [WIDTH-1:0]        wb_data
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]           cnt;
    logic [2:0]              op_f;
    logic [ROB_ID_WIDTH-1:0] tag;
    logic                    neg_res;
    logic [WIDTH-1:0]        acc_hi;    // product high half / partial remainder
    logic [WIDTH-1:0]        acc_lo;    // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0]        opnd;      // multiplicand / divisor

    // accept-side decode
    logic             accept, signed1, signed2, s1_neg, s2_neg;
    logic             by_zero, ovf, special, neg_in;
    logic [WIDTH-1:0] abs1, abs2, special_res;

    always_comb begin
        accept  = (state == IDLE) && issue_valid && !flush;
        signed1 = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
        signed2 = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        s1_neg  = signed1 && src1[WIDTH-1];
        s2_neg  = signed2 && src2[WIDTH-1];
        abs1    = s1_neg ? -src1 : src1;
        abs2    = s2_neg ? -src2 : src2;
        by_zero = (src2 == '0);
        ovf     = !funct3[0] && (src1 == MIN_NEG) && (src2 == '1);
        special = funct3[2] && (by_zero || ovf);
        if (by_zero)
            special_res = funct3[1] ? src1 : '1;
        else
            special_res = funct3[1] ? '0 : src1;
        // rem/mulhsu take only the dividend/src1 sign; mul low half is sign-agnostic
        case (funct3)
            3'b001, 3'b100: neg_in = s1_neg ^ s2_neg;
            3'b010, 3'b110: neg_in = s1_neg;
            default:        neg_in = 1'b0;
        endcase
    end

    // one iteration step and final sign fix
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_sub, nxt_hi, nxt_lo, q_fix, r_fix, final_res;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // remainder stays below the divisor, so a WIDTH-bit difference is exact
        div_sub   = div_shift[WIDTH-1:0] - opnd;
        if (op_f[2]) begin
            nxt_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod     = {nxt_hi, nxt_lo};
        prod_fix = neg_res ? -prod : prod;
        q_fix    = neg_res ? -nxt_lo : nxt_lo;
        r_fix    = neg_res ? -nxt_hi : nxt_hi;
        case (op_f)
            3'b000:                 final_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = q_fix;
            default:                final_res = r_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : BUSY;
            BUSY: if (flush) state_nxt = IDLE;
                  else if (cnt == CW'(1)) state_nxt = DONE;
            DONE: if (flush || wb_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            cnt       <= '0;
            op_f      <= '0;
            tag       <= '0;
            neg_res   <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            wb_data   <= '0;
            wb_rob_id <= '0;
        end else if (accept) begin
            op_f    <= funct3;
            tag     <= rob_id;
            neg_res <= neg_in;
            acc_hi  <= '0;
            acc_lo  <= funct3[2] ? abs1 : abs2;
            opnd    <= funct3[2] ? abs2 : abs1;
            cnt     <= special ? '0 : CNT_INIT;
            if (special) begin
                wb_data   <= special_res;
                wb_rob_id <= rob_id;
            end
        end else if (state == BUSY) begin
            if (flush) begin
                cnt <= '0;
            end else begin
                cnt    <= cnt - CW'(1);
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                if (cnt == CW'(1)) begin
                    wb_data   <= final_res;
                    wb_rob_id <= tag;
                end
            end
        end
    end

    assign issue_ready = (state == IDLE);
    assign wb_valid    = (state == DONE);
endmodule
